// File: rtl/commit_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : commit_trap_unit
// Brief    : Retires stage-6 results into the register file and machine CSRs,
//            takes traps / mret and holds a fixed-length pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trap_unit #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we6,
    input  logic [4:0]  rd6,
    input  logic [31:0] wb_data6,
    input  logic        csr_we6,
    input  logic [11:0] csr_wb_addr,
    input  logic [31:0] csr_wb,
    input  logic        exception_pending,
    input  logic [31:0] m_cause,
    input  logic [31:0] pc_exc,
    input  logic        mret6,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    localparam logic [11:0] c_CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] c_CSR_MTVEC    = 12'h305;
    localparam logic [11:0] c_CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] c_CSR_MEPC     = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE   = 12'h342;
    localparam logic [3:0]  c_FLUSH_LAST   = 4'(FLUSH_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_count, w_count_nxt;
    logic        r_flush, w_flush_nxt;
    logic        r_redirect_valid, w_redirect_valid_nxt;
    logic [31:0] r_redirect_pc, w_redirect_pc_nxt;

    logic [31:0] r_mtvec, r_mepc, r_mcause, r_mscratch;
    logic        r_mie, r_mpie;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    logic        w_flush_active, w_trap, w_mret, w_csr_wr;
    logic [31:0] w_csr_cur;

    // Only the writable bits of each CSR survive; unimplemented addresses read 0
    function automatic logic [31:0] csr_mask(input logic [11:0] addr, input logic [31:0] data);
        case (addr)
            c_CSR_MSTATUS:  csr_mask = {24'b0, data[7], 3'b0, data[3], 3'b0};
            c_CSR_MTVEC:    csr_mask = {data[31:2], 2'b00};
            c_CSR_MSCRATCH,
            c_CSR_MEPC,
            c_CSR_MCAUSE:   csr_mask = data;
            default:        csr_mask = 32'b0;
        endcase
    endfunction

    assign w_flush_active = (r_state == S_FLUSH);
    assign w_trap         = ~w_flush_active & exception_pending;
    assign w_mret         = ~w_flush_active & ~exception_pending & mret6;
    assign w_csr_wr       = ~w_flush_active & ~exception_pending & ~mret6 & csr_we6;

    always_comb begin
        w_csr_cur = 32'b0;
        case (csr_raddr)
            c_CSR_MSTATUS:  w_csr_cur = {24'b0, r_mpie, 3'b0, r_mie, 3'b0};
            c_CSR_MTVEC:    w_csr_cur = r_mtvec;
            c_CSR_MSCRATCH: w_csr_cur = r_mscratch;
            c_CSR_MEPC:     w_csr_cur = r_mepc;
            c_CSR_MCAUSE:   w_csr_cur = r_mcause;
            default:        w_csr_cur = 32'b0;
        endcase
    end

    assign csr_rdata = (w_csr_wr && (csr_wb_addr == csr_raddr)) ? csr_mask(csr_raddr, csr_wb)
                                                                : w_csr_cur;

    always_comb begin
        w_state_nxt          = r_state;
        w_count_nxt          = r_count;
        w_flush_nxt          = r_flush;
        w_redirect_valid_nxt = 1'b0;
        w_redirect_pc_nxt    = r_redirect_pc;
        case (r_state)
            S_IDLE: begin
                if (w_trap || w_mret) begin
                    w_state_nxt          = S_FLUSH;
                    w_count_nxt          = 4'd1;
                    w_flush_nxt          = 1'b1;
                    w_redirect_valid_nxt = 1'b1;
                    w_redirect_pc_nxt    = w_trap ? r_mtvec : r_mepc;
                end
            end
            S_FLUSH: begin
                if (r_count == c_FLUSH_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = 4'd0;
                    w_flush_nxt = 1'b0;
                end else begin
                    w_count_nxt = r_count + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = 4'd0;
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_count          <= 4'd0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_count          <= w_count_nxt;
            r_flush          <= w_flush_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtvec    <= MTVEC_RESET;
            r_mepc     <= 32'b0;
            r_mcause   <= 32'b0;
            r_mscratch <= 32'b0;
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
        end else if (w_trap) begin
            r_mepc   <= pc_exc;
            r_mcause <= m_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_csr_wr) begin
            case (csr_wb_addr)
                c_CSR_MSTATUS: begin
                    r_mie  <= csr_wb[3];
                    r_mpie <= csr_wb[7];
                end
                c_CSR_MTVEC:    r_mtvec    <= {csr_wb[31:2], 2'b00};
                c_CSR_MSCRATCH: r_mscratch <= csr_wb;
                c_CSR_MEPC:     r_mepc     <= csr_wb;
                c_CSR_MCAUSE:   r_mcause   <= csr_wb;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'b0;
        end else begin
            r_rf_we    <= we6 & (rd6 != 5'd0) & ~exception_pending & ~w_flush_active;
            r_rf_waddr <= rd6;
            r_rf_wdata <= wb_data6;
        end
    end

    assign rf_we          = r_rf_we;
    assign rf_waddr       = r_rf_waddr;
    assign rf_wdata       = r_rf_wdata;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;

endmodule
`default_nettype wire
